uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sincronizador_2ff.sv | 23 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8O1 UART receiver.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CNT_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        INICIAL,
        VALIDA_START,
        RECEBE,
        PARIDADE,
        STOP,
        FINAL
    } estado_t;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic paridade_impar_ok(input logic [DATA_W-1:0] dado, input logic par);
        return ^{dado, par};
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sincronizador_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] meta_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= {2{RESET_VAL}};
        end else begin
            meta_q <= {meta_q[0], d_i};
        end
    end

    assign q_o = meta_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, odd parity, one stop bit.
// Results are registered on the stop sample so they are valid while in FINAL.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              entrada_serial,
    output logic [DATA_W-1:0] dado_recebido,
    output logic              pronto,
    output logic              erro_paridade,
    output logic              erro_stop,
    output logic              ocupado
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]     CNT_FIM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     CNT_MEIO = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_FIM  = BIT_CNT_W'(DATA_W - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    estado_t              estado_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_CNT_W-1:0] bit_q;
    logic [DATA_W-1:0]    shift_q;
    logic                 paridade_ok_q;
    logic [DATA_W-1:0]    dado_q;
    logic                 pronto_q;
    logic                 erro_par_q;
    logic                 erro_stop_q;
    logic                 ocupado_q;

    sincronizador_2ff #(
        .RESET_VAL (1'b1)
    ) u_sinc (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (entrada_serial),
        .q_o    (rx_s)
    );

    // Receive FSM; every state other than INICIAL only reacts at its sample point.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_prev_q     <= 1'b1;
            estado_q      <= INICIAL;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            paridade_ok_q <= 1'b0;
            dado_q        <= '0;
            pronto_q      <= 1'b0;
            erro_par_q    <= 1'b0;
            erro_stop_q   <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            pronto_q  <= 1'b0;

            case (estado_q)
                INICIAL: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (rx_prev_q && !rx_s) begin
                        estado_q  <= VALIDA_START;
                        ocupado_q <= 1'b1;
                    end
                end

                VALIDA_START: begin
                    if (cnt_q == CNT_MEIO) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            estado_q <= RECEBE;
                        end else begin
                            estado_q  <= INICIAL;
                            ocupado_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RECEBE: begin
                    if (cnt_q == CNT_FIM) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                        bit_q   <= bit_q + BIT_CNT_W'(1);
                        if (bit_q == BIT_FIM) begin
                            estado_q <= PARIDADE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                PARIDADE: begin
                    if (cnt_q == CNT_FIM) begin
                        cnt_q         <= '0;
                        paridade_ok_q <= paridade_impar_ok(shift_q, rx_s);
                        estado_q      <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_FIM) begin
                        cnt_q       <= '0;
                        dado_q      <= shift_q;
                        erro_par_q  <= ~paridade_ok_q;
                        erro_stop_q <= ~rx_s;
                        pronto_q    <= 1'b1;
                        estado_q    <= FINAL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                FINAL: begin
                    estado_q  <= INICIAL;
                    ocupado_q <= 1'b0;
                end

                default: begin
                    estado_q  <= INICIAL;
                    ocupado_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign dado_recebido = dado_q;
    assign pronto        = pronto_q;
    assign erro_paridade = erro_par_q;
    assign erro_stop     = erro_stop_q;
    assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned C   = 16;
    localparam int          LAT = 3 + C / 2 + 10 * C;

    typedef struct {
        logic [7:0] dado;
        logic       perr;
        logic       serr;
        int         fall;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] dado;
    logic       pronto;
    logic       erro_par;
    logic       erro_stop;
    logic       ocupado;

    exp_t exp_q[$];
    int   checks     = 0;
    int   fails      = 0;
    int   cyc        = 0;
    int   pronto_cnt = 0;

    uart_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clock          (clk),
        .reset          (rst_n),
        .entrada_serial (rx),
        .dado_recebido  (dado),
        .pronto         (pronto),
        .erro_paridade  (erro_par),
        .erro_stop      (erro_stop),
        .ocupado        (ocupado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (pronto === 1'b1) pronto_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Drive one frame starting at the current negedge; optionally record the expected result.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit push);
        logic [FRAME_BITS-1:0] bits;
        exp_t e;
        bits   = {stp, par, d, 1'b0};
        e.dado = d;
        e.perr = ~(^{d, par});
        e.serr = ~stp;
        e.fall = cyc;
        if (push) exp_q.push_back(e);
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx = bits[i];
            repeat (C) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_pronto(input int budget, output bit got, output logic [7:0] d,
                               output logic pe, output logic se, output int at,
                               output logic p_after, output logic o_after);
        got = 0; d = '0; pe = 1'b0; se = 1'b0; at = 0; p_after = 1'b1; o_after = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pronto === 1'b1) begin
                got = 1; d = dado; pe = erro_par; se = erro_stop; at = cyc;
                @(negedge clk);
                p_after = pronto;
                o_after = ocupado;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dado !== 8'h00)   begin fails++; $display("FAIL reset_dado: got %h want 00", dado); end
        checks++; if (pronto !== 1'b0)  begin fails++; $display("FAIL reset_pronto: got %b want 0", pronto); end
        checks++; if (erro_par !== 1'b0) begin fails++; $display("FAIL reset_erro_par: got %b want 0", erro_par); end
        checks++; if (erro_stop !== 1'b0) begin fails++; $display("FAIL reset_erro_stop: got %b want 0", erro_stop); end
        checks++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        rst_n = 1'b1;
        repeat (C) @(negedge clk);
        checks++; if (ocupado !== 1'b0) begin fails++; $display("FAIL idle_ocupado: got %b want 0", ocupado); end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic par, input logic stp);
        bit got; logic [7:0] gd; logic pe, se, pa, oa; int at; exp_t e;
        fork
            send_frame(d, par, stp, 1'b1);
            wait_pronto(LAT + C, got, gd, pe, se, at, pa, oa);
        join
        checks++;
        if (!got || exp_q.size() == 0) begin
            fails++; $display("FAIL %s_pronto: got no pronto (queued %0d) want one", name, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        checks++; if (gd !== e.dado) begin fails++; $display("FAIL %s_dado: got %h want %h", name, gd, e.dado); end
        checks++; if (pe !== e.perr) begin fails++; $display("FAIL %s_erro_par: got %b want %b", name, pe, e.perr); end
        checks++; if (se !== e.serr) begin fails++; $display("FAIL %s_erro_stop: got %b want %b", name, se, e.serr); end
        checks++;
        if (at - e.fall < LAT - 1 || at - e.fall > LAT + 1) begin
            fails++; $display("FAIL %s_latency: got %0d want %0d+/-1", name, at - e.fall, LAT);
        end
        checks++; if (pa !== 1'b0) begin fails++; $display("FAIL %s_pulse: got pronto %b next cycle want 0", name, pa); end
        checks++; if (oa !== 1'b0) begin fails++; $display("FAIL %s_ocupado_end: got %b want 0", name, oa); end
        repeat (C) @(negedge clk);
    endtask

    task automatic test_glitch();
        int p0; logic [7:0] d0; logic pe0, se0;
        p0 = pronto_cnt; d0 = dado; pe0 = erro_par; se0 = erro_stop;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ocupado !== 1'b1) begin fails++; $display("FAIL glitch_detect: got ocupado %b want 1", ocupado); end
        repeat (6) @(negedge clk);
        checks++; if (ocupado !== 1'b0) begin fails++; $display("FAIL glitch_ocupado: got %b want 0", ocupado); end
        repeat (2 * C) @(negedge clk);
        checks++; if (pronto_cnt !== p0) begin fails++; $display("FAIL glitch_pronto: got %0d pulses want %0d", pronto_cnt, p0); end
        checks++; if (dado !== d0) begin fails++; $display("FAIL glitch_dado: got %h want %h", dado, d0); end
        checks++; if (erro_par !== pe0 || erro_stop !== se0) begin
            fails++; $display("FAIL glitch_flags: got %b%b want %b%b", erro_par, erro_stop, pe0, se0);
        end
    endtask

    task automatic test_back_to_back();
        bit g1, g2; logic [7:0] d1, d2; logic pe1, se1, pe2, se2, pa1, oa1, pa2, oa2; int at1, at2;
        exp_t e;
        fork
            begin
                send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
                send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
            end
            begin
                wait_pronto(LAT + C, g1, d1, pe1, se1, at1, pa1, oa1);
                wait_pronto(LAT + 2 * C, g2, d2, pe2, se2, at2, pa2, oa2);
            end
        join
        checks++;
        if (!g1 || !g2 || exp_q.size() != 2) begin
            fails++; $display("FAIL b2b_pronto: got pulses %0d%0d (queued %0d) want both", g1, g2, exp_q.size());
            exp_q.delete();
            return;
        end
        e = exp_q.pop_front();
        checks++; if (d1 !== e.dado) begin fails++; $display("FAIL b2b_dado1: got %h want %h", d1, e.dado); end
        checks++; if ({pe1, se1} !== {e.perr, e.serr}) begin fails++; $display("FAIL b2b_flags1: got %b%b want %b%b", pe1, se1, e.perr, e.serr); end
        checks++; if (at1 - e.fall < LAT - 1 || at1 - e.fall > LAT + 1) begin fails++; $display("FAIL b2b_latency1: got %0d want %0d", at1 - e.fall, LAT); end
        e = exp_q.pop_front();
        checks++; if (d2 !== e.dado) begin fails++; $display("FAIL b2b_dado2: got %h want %h", d2, e.dado); end
        checks++; if ({pe2, se2} !== {e.perr, e.serr}) begin fails++; $display("FAIL b2b_flags2: got %b%b want %b%b", pe2, se2, e.perr, e.serr); end
        checks++; if (at2 - e.fall < LAT - 1 || at2 - e.fall > LAT + 1) begin fails++; $display("FAIL b2b_latency2: got %0d want %0d", at2 - e.fall, LAT); end
        repeat (C) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int p0;
        p0 = pronto_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
            begin
                repeat (5 * C + C / 2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (2 * C) @(negedge clk);
        checks++; if (pronto_cnt !== p0) begin fails++; $display("FAIL abort_pronto: got %0d pulses want %0d", pronto_cnt, p0); end
        checks++; if (dado !== 8'h00) begin fails++; $display("FAIL abort_dado: got %h want 00", dado); end
        checks++; if (ocupado !== 1'b0) begin fails++; $display("FAIL abort_ocupado: got %b want 0", ocupado); end
        test_frame("after_abort", 8'h81, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_frame("good_55", 8'h55, 1'b1, 1'b1);
        test_frame("parity_07", 8'h07, 1'b1, 1'b1);
        test_frame("stop_41", 8'h41, 1'b1, 1'b0);
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
